// File: rtl/rr_priority_encoder.sv
// Registered N-way priority encoder / arbiter: fixed (highest index) or round-robin selection.
// Latency: 1 clock from sampled I/E to Y/V/G; one decision per clock. No backpressure; E=0 suppresses the grant.
// Optional grant lock enabled by defining RR_PRIORITY_ENCODER_LOCK_EN.
module rr_priority_encoder #(
    parameter int N  = 4,
    parameter int W  = $clog2(N),
    parameter int RR = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E,
    input  logic [N-1:0] I,
    output logic [W-1:0] Y,
    output logic         V,
    output logic [N-1:0] G
);

    logic [W-1:0] y_q, y_d;
    logic         v_q, v_d;
    logic [N-1:0] g_q, g_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         win_vld;
    logic [W-1:0] win_idx;
    logic [W:0]   scan_pos;
    logic [W-1:0] fix_pos;
    logic         lock_hold;

    // One extra bit so ptr + offset (at most 2N-2) cannot overflow before the wrap.
    always_comb begin
        win_vld  = |I;
        win_idx  = '0;
        scan_pos = '0;
        fix_pos  = '0;
        if (RR != 0) begin
            // Walk offsets from farthest to nearest so the nearest set bit is assigned last.
            for (int j = N - 1; j >= 0; j--) begin
                scan_pos = {1'b0, ptr_q} + (W+1)'(j);
                if (scan_pos >= (W+1)'(N)) begin
                    scan_pos = scan_pos - (W+1)'(N);
                end
                if (I[scan_pos[W-1:0]]) begin
                    win_idx = scan_pos[W-1:0];
                end
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                fix_pos = W'(j);
                if (I[fix_pos]) begin
                    win_idx = fix_pos;
                end
            end
        end
    end

`ifdef RR_PRIORITY_ENCODER_LOCK_EN
    assign lock_hold = v_q & E & I[y_q];
`else
    assign lock_hold = 1'b0;
`endif

    // The E check comes first so undefined request bits while disabled cannot reach ptr.
    always_comb begin
        y_d   = '0;
        v_d   = 1'b0;
        g_d   = '0;
        ptr_d = ptr_q;
        if (lock_hold) begin
            y_d = y_q;
            v_d = v_q;
            g_d = g_q;
        end else if (E && win_vld) begin
            y_d          = win_idx;
            v_d          = 1'b1;
            g_d[win_idx] = 1'b1;
            if (RR != 0) begin
                ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            v_q   <= 1'b0;
            g_q   <= '0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            v_q   <= v_d;
            g_q   <= g_d;
            ptr_q <= ptr_d;
        end
    end

    assign Y = y_q;
    assign V = v_q;
    assign G = g_q;

endmodule
